// File: rtl/pokey_controller_emulator.sv
// 5200-style controller responder for POKEY: keypad scan answer,
// pot-line charge model and side-button lines.
module pokey_controller_emulator #(
    parameter int POT_MAX    = 228,
    parameter int KR_LATENCY = 1,
    parameter int POT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_scan_L,
    input  logic [1:0]       pot_rel,
    input  logic             pot_tick,
    input  logic [15:0]      key_pressed,
    input  logic [POT_W-1:0] pot0_val,
    input  logic [POT_W-1:0] pot1_val,
    input  logic             pot_load,
    input  logic             break_pressed,
    input  logic             trig_pressed,
    output logic             kr1_L,
    output logic             kr2_L,
    output logic [1:0]       pot_scan,
    output logic [1:0]       pot_charging,
    output logic             trig_L
);

    localparam logic [1:0] ST_DUMP   = 2'd0;
    localparam logic [1:0] ST_CHARGE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [POT_W-1:0] POT_MAX_W = POT_W'(POT_MAX);
    localparam logic [POT_W-1:0] CNT_SAT   = '1;

    function automatic logic [POT_W-1:0] clamp(
        input logic [POT_W-1:0] v
    );
        return (v > POT_MAX_W) ? POT_MAX_W : v;
    endfunction

    logic [3:0]            key_idx;
    logic [KR_LATENCY-1:0] kr_pipe;

    assign key_idx = ~key_scan_L;
    assign kr1_L   = kr_pipe[KR_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kr_pipe <= '1;
        end else begin
            kr_pipe[0] <= ~key_pressed[key_idx];
            for (int i = 1; i < KR_LATENCY; i++)
                kr_pipe[i] <= kr_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kr2_L  <= 1'b1;
            trig_L <= 1'b1;
        end else begin
            kr2_L  <= ~break_pressed;
            trig_L <= ~trig_pressed;
        end
    end

    logic [POT_W-1:0] load_val [2];

    assign load_val[0] = clamp(pot0_val);
    assign load_val[1] = clamp(pot1_val);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]       state;
        logic [POT_W-1:0] shadow;
        logic [POT_W-1:0] tgt;
        logic [POT_W-1:0] cnt;
        logic [POT_W-1:0] cnt_nxt;
        logic             scan;

        // Compare against the post-tick count so the threshold
        // crossing lands on the edge of the final tick.
        assign cnt_nxt = (pot_tick && cnt != CNT_SAT)
                       ? cnt + 1'b1 : cnt;

        assign pot_scan[c]     = scan;
        assign pot_charging[c] = (state == ST_CHARGE);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= ST_DUMP;
                shadow <= POT_MAX_W;
                tgt    <= POT_MAX_W;
                cnt    <= '0;
                scan   <= 1'b0;
            end else begin
                if (pot_load)
                    shadow <= load_val[c];
                case (state)
                    ST_DUMP: begin
                        cnt  <= '0;
                        scan <= 1'b0;
                        if (pot_rel[c]) begin
                            state <= ST_CHARGE;
                            tgt   <= pot_load ? load_val[c]
                                              : shadow;
                        end
                    end
                    ST_CHARGE: begin
                        if (!pot_rel[c]) begin
                            state <= ST_DUMP;
                            cnt   <= '0;
                            scan  <= 1'b0;
                        end else begin
                            cnt <= cnt_nxt;
                            if (cnt_nxt == tgt) begin
                                state <= ST_DONE;
                                scan  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!pot_rel[c]) begin
                            state <= ST_DUMP;
                            cnt   <= '0;
                            scan  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_DUMP;
                        cnt   <= '0;
                        scan  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pokey_controller_emulator.sv
// Scoreboard bench for pokey_controller_emulator: expectations are
// queued at stimulus time and retired when their cycle comes due.
module tb_pokey_controller_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_scan_L;
    logic [1:0] pot_rel;
    logic       pot_tick;
    logic [15:0] key_pressed;
    logic [7:0] pot0_val;
    logic [7:0] pot1_val;
    logic       pot_load;
    logic       break_pressed;
    logic       trig_pressed;
    logic       kr1_L, kr2_L, trig_L;
    logic [1:0] pot_scan, pot_charging;
    logic       b_kr1_L, b_kr2_L, b_trig_L;
    logic [1:0] b_pot_scan, b_pot_charging;

    pokey_controller_emulator u_dut (
        .clk(clk), .rst(rst),
        .key_scan_L(key_scan_L), .pot_rel(pot_rel),
        .pot_tick(pot_tick), .key_pressed(key_pressed),
        .pot0_val(pot0_val), .pot1_val(pot1_val),
        .pot_load(pot_load), .break_pressed(break_pressed),
        .trig_pressed(trig_pressed), .kr1_L(kr1_L),
        .kr2_L(kr2_L), .pot_scan(pot_scan),
        .pot_charging(pot_charging), .trig_L(trig_L)
    );

    pokey_controller_emulator #(.POT_MAX(255)) u_dut255 (
        .clk(clk), .rst(rst),
        .key_scan_L(key_scan_L), .pot_rel(pot_rel),
        .pot_tick(pot_tick), .key_pressed(key_pressed),
        .pot0_val(pot0_val), .pot1_val(pot1_val),
        .pot_load(pot_load), .break_pressed(break_pressed),
        .trig_pressed(trig_pressed), .kr1_L(b_kr1_L),
        .kr2_L(b_kr2_L), .pot_scan(b_pot_scan),
        .pot_charging(b_pot_charging), .trig_L(b_trig_L)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
        int    due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   lows;

    function automatic int observe(int sel);
        case (sel)
            0: return int'(kr1_L);
            1: return int'(kr2_L);
            2: return int'(trig_L);
            3: return int'(pot_scan[0]);
            4: return int'(pot_scan[1]);
            5: return int'(pot_charging[0]);
            6: return int'(pot_charging[1]);
            7: return int'(b_pot_scan[0]);
            default: return -1;
        endcase
    endfunction

    task automatic check_eq(string tag, int obs, int exp);
        n_total++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
    endtask

    task automatic expect_at(string tag, int sel, int exp, int dly);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        e.due = cyc + dly;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                check_eq(sbq[i].tag, observe(sbq[i].sel), sbq[i].exp);
                sbq.delete(i);
            end
        end
    endtask

    task automatic do_tick(int gap);
        pot_tick = 1'b1;
        step();
        pot_tick = 1'b0;
        for (int i = 1; i < gap; i++)
            step();
    endtask

    task automatic mark(int k, int tgt, int sel, string tag);
        if (k == tgt - 1)
            expect_at({tag, "_early"}, sel, 0, 1);
        if (k == tgt)
            expect_at({tag, "_rise"}, sel, 1, 1);
    endtask

    task automatic load(logic [7:0] v0, logic [7:0] v1);
        pot0_val = v0;
        pot1_val = v1;
        pot_load = 1'b1;
        step();
        pot_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        key_scan_L = 4'hF;
        pot_rel = 2'b00;
        pot_tick = 1'b0;
        key_pressed = 16'h0000;
        pot0_val = 8'd0;
        pot1_val = 8'd0;
        pot_load = 1'b0;
        break_pressed = 1'b0;
        trig_pressed = 1'b0;
        repeat (2) step();
        check_eq("rst_kr1", int'(kr1_L), 1);
        check_eq("rst_kr2", int'(kr2_L), 1);
        check_eq("rst_trig", int'(trig_L), 1);
        check_eq("rst_scan", int'(pot_scan), 0);
        check_eq("rst_chg", int'(pot_charging), 0);
        rst = 1'b0;
        step();

        key_pressed = 16'h0020;
        key_scan_L = 4'b1010;
        expect_at("key5_hit", 0, 0, 1);
        step();
        key_scan_L = 4'b1011;
        expect_at("key4_miss", 0, 1, 1);
        step();

        key_pressed = 16'h0080;
        lows = 0;
        for (int c = 0; c < 16; c++) begin
            key_scan_L = ~4'(c);
            expect_at($sformatf("sweep%0d", c), 0,
                      (c == 7) ? 0 : 1, 1);
            step();
            if (kr1_L == 1'b0)
                lows++;
        end
        check_eq("sweep_lows", lows, 1);

        key_scan_L = ~4'd3;
        key_pressed = 16'h0008;
        expect_at("key_both", 0, 0, 1);
        step();

        break_pressed = 1'b1;
        trig_pressed = 1'b1;
        expect_at("brk_on", 1, 0, 1);
        expect_at("trg_on", 2, 0, 1);
        step();
        break_pressed = 1'b0;
        trig_pressed = 1'b0;
        expect_at("brk_off", 1, 1, 1);
        expect_at("trg_off", 2, 1, 1);
        step();

        load(8'd10, 8'd0);
        pot_rel[0] = 1'b1;
        expect_at("p0_chg", 5, 1, 1);
        step();
        for (int k = 1; k <= 10; k++) begin
            mark(k, 10, 3, "p0");
            do_tick(4);
        end
        pot_rel[0] = 1'b0;
        expect_at("p0_drop", 3, 0, 1);
        expect_at("p0_dump", 5, 0, 1);
        step();

        load(8'd0, 8'd250);
        pot_rel[1] = 1'b1;
        step();
        for (int k = 1; k <= 229; k++) begin
            mark(k, 228, 4, "p1clamp");
            do_tick(1);
        end
        pot_rel[1] = 1'b0;
        step();

        load(8'd0, 8'd0);
        pot_rel[1] = 1'b1;
        expect_at("p1zero_wait", 4, 0, 1);
        expect_at("p1zero_rise", 4, 1, 2);
        step();
        step();
        pot_rel[1] = 1'b0;
        step();

        load(8'd255, 8'd0);
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 260; k++) begin
            mark(k, 228, 3, "p0sat");
            mark(k, 255, 7, "b_sat");
            if (k == 260)
                expect_at("b_hold", 7, 1, 1);
            do_tick(1);
        end
        pot_rel[0] = 1'b0;
        step();

        load(8'd20, 8'd0);
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                pot0_val = 8'd7;
                pot_load = 1'b1;
            end
            mark(k, 20, 3, "p0mid");
            do_tick(1);
            pot_load = 1'b0;
        end
        pot_rel[0] = 1'b0;
        step();
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 7; k++) begin
            mark(k, 7, 3, "p0next");
            do_tick(2);
        end

        pot_rel[0] = 1'b0;
        step();
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 4; k++)
            do_tick(1);
        pot_rel[0] = 1'b0;
        expect_at("drop_chg", 5, 0, 1);
        expect_at("drop_scan", 3, 0, 1);
        do_tick(1);
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 7; k++) begin
            mark(k, 7, 3, "p0zeroed");
            do_tick(1);
        end
        pot_rel[0] = 1'b0;
        step();

        pot0_val = 8'd3;
        pot_load = 1'b1;
        pot_rel[0] = 1'b1;
        step();
        pot_load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            mark(k, 3, 3, "p0bypass");
            do_tick(1);
        end
        check_eq("pre_rst_scan", int'(pot_scan[0]), 1);

        break_pressed = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmid_scan", int'(pot_scan), 0);
        check_eq("rstmid_chg", int'(pot_charging), 0);
        check_eq("rstmid_kr1", int'(kr1_L), 1);
        check_eq("rstmid_kr2", int'(kr2_L), 1);
        check_eq("rstmid_trig", int'(trig_L), 1);
        pot_rel = 2'b00;
        break_pressed = 1'b0;
        step();
        rst = 1'b0;
        step();
        pot_rel[0] = 1'b1;
        step();
        for (int k = 1; k <= 229; k++) begin
            mark(k, 228, 3, "p0rst");
            do_tick(1);
        end
        pot_rel[0] = 1'b0;
        step();

        if (sbq.size() != 0)
            check_eq("sb_drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
